// File: rtl/ctrl_frame_injector_if.sv
// ---------------------------------------------------------------------------
// ctrl_frame_injector_if
//   Bundles the picosoc iomem bus and the switch Body/Header FIFO write ports
//   used by ctrl_frame_injector.
//
//   iomem_*   : picosoc request (valid/wstrb/addr/wdata) and response
//               (ready/rdata).
//   b_fifo_*  : body byte stream: din, wren and del_in out, full back in.
//   h_fifo_*  : header word: din and wren out, full back in.
//
//   modport master : the picosoc + FIFO environment around the injector.
//   modport slave  : the injector itself.
// ---------------------------------------------------------------------------
interface ctrl_frame_injector_if #(
    parameter int HEADER_DWIDTH = 128
);
    logic [HEADER_DWIDTH-1:0] h_fifo_din;
    logic                     h_fifo_wren;
    logic                     h_fifo_full;
    logic [7:0]               b_fifo_din;
    logic                     b_fifo_wren;
    logic                     b_fifo_del_in;
    logic                     b_fifo_full;
    logic                     iomem_valid;
    logic                     iomem_ready;
    logic [3:0]               iomem_wstrb;
    logic [31:0]              iomem_addr;
    logic [31:0]              iomem_wdata;
    logic [31:0]              iomem_rdata;

    modport master (
        input  h_fifo_din, h_fifo_wren, b_fifo_din, b_fifo_wren, b_fifo_del_in,
        input  iomem_ready, iomem_rdata,
        output h_fifo_full, b_fifo_full,
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata
    );

    modport slave (
        output h_fifo_din, h_fifo_wren, b_fifo_din, b_fifo_wren, b_fifo_del_in,
        output iomem_ready, iomem_rdata,
        input  h_fifo_full, b_fifo_full,
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata
    );
endinterface

// File: rtl/ctrl_frame_injector.sv
// ---------------------------------------------------------------------------
// ctrl_frame_injector
//   Firmware composes a control frame (15..64 bytes) in one of two 16-word
//   slots through the iomem data window (0x05xx_xxxx), then launches it via
//   the config register (0x15xx_xxxx). The block streams frame bytes 14..len-1
//   into the Body FIFO (delimiter on the last byte), and only afterwards
//   writes the 128-bit header built from bytes 0..13 into the Header FIFO.
//
//   clk, arst_n : clock, asynchronous active-low reset
//   bus         : ctrl_frame_injector_if.slave (iomem bus + FIFO write ports)
// ---------------------------------------------------------------------------
module ctrl_frame_injector #(
    parameter int HEADER_DWIDTH = 128,
    parameter int MIN_LEN       = 15,
    parameter int MAX_LEN       = 64
) (
    input  logic                 clk,
    input  logic                 arst_n,
    ctrl_frame_injector_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_BODY, S_HDR, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [5:0]      idx_q, idx_d;
    logic            cpu_slot_q, cpu_slot_d;
    logic            tx_slot_q, tx_slot_d;
    logic [1:0]      pending_q, pending_d;
    logic            err_q, err_d;
    logic [1:0][3:0] mask_q, mask_d;
    logic [1:0][6:0] len_q, len_d;
    logic            ready_q, ready_d;
    logic [31:0]     rdata_q, rdata_d;

    // Two frame slots, read asynchronously so a body byte is available in the
    // same cycle its index is presented.
    logic [31:0] slot_mem [2][16];

    logic        sel_data, sel_cfg, access;
    logic        cfg_wr, send_req, len_ok, send_ok;
    logic [3:0]  mem_we;
    logic [31:0] status;
    logic        b_wren, b_del, h_wren, tx_done;
    logic [6:0]  cur_len;
    logic [31:0] tx_word;
    logic [7:0]  body_byte;
    logic [127:0] header;
    logic        unused_addr_bits;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // ---------------- iomem decode ----------------
    assign sel_data = bus.iomem_valid && (bus.iomem_addr[31:24] == 8'h05);
    assign sel_cfg  = bus.iomem_valid && (bus.iomem_addr[31:24] == 8'h15);
    // One access per request: act only on the cycle before ready is raised.
    assign access   = (sel_data || sel_cfg) && !ready_q;

    assign cfg_wr   = access && sel_cfg && bus.iomem_wstrb[3];
    assign send_req = cfg_wr && bus.iomem_wdata[31];
    // Full 11-bit length is checked, so oversized values never alias into range.
    assign len_ok   = (bus.iomem_wdata[10:0] >= 11'(MIN_LEN)) &&
                      (bus.iomem_wdata[10:0] <= 11'(MAX_LEN));
    assign send_ok  = send_req && len_ok && (pending_q != 2'd2);
    assign mem_we   = (access && sel_data) ? bus.iomem_wstrb : 4'b0000;

    assign status = {(pending_q != 2'd2), (state_q != S_IDLE), err_q,
                     pending_q, cpu_slot_q, 26'd0};

    assign unused_addr_bits = ^{bus.iomem_addr[23:6], bus.iomem_addr[1:0]};

    // ---------------- transmit datapath ----------------
    assign cur_len   = len_q[tx_slot_q];
    assign tx_word   = slot_mem[tx_slot_q][idx_q[5:2]];
    assign body_byte = tx_word[{idx_q[1:0], 3'b000} +: 8];

    // Bytes 0..13 little-endian in words 0..3 become a big-endian field.
    assign header = {mask_q[tx_slot_q], 9'd0, 1'b1, 2'd0,
                     bswap(slot_mem[tx_slot_q][0]),
                     bswap(slot_mem[tx_slot_q][1]),
                     bswap(slot_mem[tx_slot_q][2]),
                     slot_mem[tx_slot_q][3][7:0], slot_mem[tx_slot_q][3][15:8]};

    // ---------------- FSM next state / strobes ----------------
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        b_wren  = 1'b0;
        b_del   = 1'b0;
        h_wren  = 1'b0;
        tx_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                idx_d = 6'd14;
                if (pending_q != 2'd0) state_d = S_BODY;
            end
            S_BODY: begin
                if (!bus.b_fifo_full) begin
                    b_wren = 1'b1;
                    idx_d  = idx_q + 6'd1;
                    if ({1'b0, idx_q} == cur_len - 7'd1) begin
                        b_del   = 1'b1;
                        state_d = S_HDR;
                    end
                end
            end
            S_HDR: begin
                if (!bus.h_fifo_full) begin
                    h_wren  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                tx_done = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- CPU side / slot bookkeeping ----------------
    always_comb begin
        cpu_slot_d = cpu_slot_q;
        tx_slot_d  = tx_slot_q;
        pending_d  = pending_q;
        err_d      = err_q;
        mask_d     = mask_q;
        len_d      = len_q;
        ready_d    = access;
        rdata_d    = rdata_q;

        if (access) rdata_d = sel_data ? slot_mem[cpu_slot_q][bus.iomem_addr[5:2]] : status;

        // A failing send wins over clear_err in the same write.
        if (cfg_wr && bus.iomem_wdata[30]) err_d = 1'b0;
        if (send_req && !send_ok)          err_d = 1'b1;

        if (send_ok) begin
            mask_d[cpu_slot_q] = bus.iomem_wdata[27:24];
            len_d[cpu_slot_q]  = bus.iomem_wdata[6:0];
            cpu_slot_d         = !cpu_slot_q;
        end
        if (tx_done) tx_slot_d = !tx_slot_q;

        case ({send_ok, tx_done})
            2'b10:   pending_d = pending_q + 2'd1;
            2'b01:   pending_d = pending_q - 2'd1;
            default: pending_d = pending_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 6'd14;
            cpu_slot_q <= 1'b0;
            tx_slot_q  <= 1'b0;
            pending_q  <= 2'd0;
            err_q      <= 1'b0;
            mask_q     <= '0;
            len_q      <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cpu_slot_q <= cpu_slot_d;
            tx_slot_q  <= tx_slot_d;
            pending_q  <= pending_d;
            err_q      <= err_d;
            mask_q     <= mask_d;
            len_q      <= len_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
        end
    end

    // NOTE: the slot buffer is deliberately not reset; firmware always writes
    // a frame before sending it, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we[0]) slot_mem[cpu_slot_q][bus.iomem_addr[5:2]][7:0]   <= bus.iomem_wdata[7:0];
        if (mem_we[1]) slot_mem[cpu_slot_q][bus.iomem_addr[5:2]][15:8]  <= bus.iomem_wdata[15:8];
        if (mem_we[2]) slot_mem[cpu_slot_q][bus.iomem_addr[5:2]][23:16] <= bus.iomem_wdata[23:16];
        if (mem_we[3]) slot_mem[cpu_slot_q][bus.iomem_addr[5:2]][31:24] <= bus.iomem_wdata[31:24];
    end

    // ---------------- outputs (data gated to 0 when not strobed) ----------------
    assign bus.b_fifo_wren   = b_wren;
    assign bus.b_fifo_del_in = b_del;
    assign bus.b_fifo_din    = b_wren ? body_byte : 8'd0;
    assign bus.h_fifo_wren   = h_wren;
    assign bus.h_fifo_din    = h_wren ? HEADER_DWIDTH'(header) : '0;
    assign bus.iomem_ready   = ready_q;
    assign bus.iomem_rdata   = rdata_q;

endmodule

// File: tb/tb_ctrl_frame_injector.sv
// ---------------------------------------------------------------------------
// tb_ctrl_frame_injector
//   Directed bench for ctrl_frame_injector. Frames use DST 01:80:C2:00:00:00
//   in bytes 0..5 and (index XOR tag) in every later byte, so each frame's
//   content identifies which slot it came from.
// ---------------------------------------------------------------------------
module tb_ctrl_frame_injector;

    localparam logic [31:0] DATA_BASE = 32'h0500_0000;
    localparam logic [31:0] CFG_ADDR  = 32'h1500_0000;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    ctrl_frame_injector_if #(.HEADER_DWIDTH(128)) bus ();

    ctrl_frame_injector #(
        .HEADER_DWIDTH(128),
        .MIN_LEN      (15),
        .MAX_LEN      (64)
    ) dut (
        .clk   (clk),
        .arst_n(arst_n),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;

    // ---------------- FIFO-side monitor ----------------
    logic [7:0]   body_q [$];
    logic         del_q  [$];
    logic [127:0] hdr_q  [$];
    int           b_viol = 0;
    int           h_viol = 0;

    always @(negedge clk) begin
        if (bus.b_fifo_wren) begin
            body_q.push_back(bus.b_fifo_din);
            del_q.push_back(bus.b_fifo_del_in);
            if (bus.b_fifo_full) b_viol++;
        end
        if (bus.h_fifo_wren) begin
            hdr_q.push_back(bus.h_fifo_din);
            if (bus.h_fifo_full) h_viol++;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish within 500 us");
        $fatal(1, "watchdog");
    end

    // ---------------- frame model ----------------
    function automatic logic [7:0] fbyte(input int b, input logic [7:0] tag);
        case (b)
            0:       return 8'h01;
            1:       return 8'h80;
            2:       return 8'hC2;
            3, 4, 5: return 8'h00;
            default: return 8'(b) ^ tag;
        endcase
    endfunction

    function automatic logic [31:0] fword(input int k, input logic [7:0] tag);
        return {fbyte(4*k+3, tag), fbyte(4*k+2, tag), fbyte(4*k+1, tag), fbyte(4*k, tag)};
    endfunction

    function automatic logic [127:0] exp_hdr(input logic [3:0] mask, input logic [7:0] tag);
        logic [127:0] h;
        h = '0;
        h[127:124] = mask;
        h[114] = 1'b1;
        for (int b = 0; b < 14; b++) h[111-8*b -: 8] = fbyte(b, tag);
        return h;
    endfunction

    // ---------------- bus tasks ----------------
    task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, output logic [31:0] rdata);
        bit got;
        got   = 1'b0;
        rdata = 32'hx;
        @(posedge clk); #1;
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = addr;
        bus.iomem_wdata = wdata;
        bus.iomem_wstrb = strb;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.iomem_ready) begin
                got   = 1'b1;
                rdata = bus.iomem_rdata;
            end
        end
        @(posedge clk); #1;
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'd0;
        if (!got) begin
            total++;
            $display("FAIL bus_timeout: addr=%h got no iomem_ready within 20 cycles", addr);
        end
    endtask

    task automatic cfg_write(input logic [31:0] wdata);
        logic [31:0] rd;
        bus_access(CFG_ADDR, wdata, 4'hF, rd);
    endtask

    task automatic cfg_read(output logic [31:0] rd);
        bus_access(CFG_ADDR, 32'd0, 4'h0, rd);
    endtask

    task automatic write_frame(input logic [7:0] tag);
        logic [31:0] rd;
        for (int k = 0; k < 16; k++) bus_access(DATA_BASE + 32'(4*k), fword(k, tag), 4'hF, rd);
    endtask

    task automatic wait_count(input int which, input int n, input int budget, input string name);
        int c;
        c = 0;
        while (((which == 0) ? body_q.size() : hdr_q.size()) < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (((which == 0) ? body_q.size() : hdr_q.size()) < n)
            $display("FAIL %s: count=%0d required>=%0d after %0d cycles", name,
                     (which == 0) ? body_q.size() : hdr_q.size(), n, budget);
        else passed++;
    endtask

    task automatic clear_mon();
        body_q.delete();
        del_q.delete();
        hdr_q.delete();
        b_viol = 0;
        h_viol = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd;
        bus.iomem_valid = 1'b0; bus.iomem_addr = '0; bus.iomem_wdata = '0; bus.iomem_wstrb = '0;
        bus.b_fifo_full = 1'b0; bus.h_fifo_full = 1'b0;
        arst_n = 1'b0;
        #23;
        total++;
        if ({bus.b_fifo_wren, bus.b_fifo_del_in, bus.h_fifo_wren, bus.iomem_ready} !== 4'b0)
            $display("FAIL reset_strobes: got %b required 0000",
                     {bus.b_fifo_wren, bus.b_fifo_del_in, bus.h_fifo_wren, bus.iomem_ready});
        else passed++;
        total++;
        if (bus.iomem_rdata !== 32'd0 || bus.b_fifo_din !== 8'd0 || bus.h_fifo_din !== 128'd0)
            $display("FAIL reset_data: rdata=%h bdin=%h hdin=%h required all 0",
                     bus.iomem_rdata, bus.b_fifo_din, bus.h_fifo_din);
        else passed++;
        @(negedge clk); arst_n = 1'b1;
        cfg_read(rd);
        total++;
        if (rd !== 32'h8000_0000) $display("FAIL reset_cfg: got %h required 80000000", rd);
        else passed++;
        @(negedge clk);
        total++;
        if (bus.iomem_ready !== 1'b0) $display("FAIL ready_one_cycle: got %b required 0", bus.iomem_ready);
        else passed++;
    endtask

    task automatic test_decode();
        logic [31:0] rd;
        bit seen;
        // Per-byte strobes on slot 0 word 0.
        bus_access(DATA_BASE, 32'hFFFF_FFFF, 4'hF, rd);
        bus_access(DATA_BASE, 32'h1122_3344, 4'b0101, rd);
        bus_access(DATA_BASE, 32'd0, 4'h0, rd);
        total++;
        if (rd !== 32'hFF22_FF44) $display("FAIL wstrb_merge: got %h required ff22ff44", rd);
        else passed++;
        // Undecoded address never acknowledged.
        seen = 1'b0;
        @(posedge clk); #1;
        bus.iomem_valid = 1'b1; bus.iomem_addr = 32'h0600_0000; bus.iomem_wstrb = 4'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.iomem_ready) seen = 1'b1;
        end
        @(posedge clk); #1; bus.iomem_valid = 1'b0;
        total++;
        if (seen) $display("FAIL undecoded_ready: got ready=1 required 0");
        else passed++;
    endtask

    task automatic test_bpdu();
        logic [31:0] rd;
        int errs;
        clear_mon();
        write_frame(8'h00);
        bus_access(DATA_BASE, 32'd0, 4'h0, rd);
        total++;
        if (rd !== 32'h00C2_8001) $display("FAIL bpdu_word0: got %h required 00c28001", rd);
        else passed++;
        bus_access(DATA_BASE + 32'd60, 32'd0, 4'h0, rd);
        total++;
        if (rd !== 32'h3F3E_3D3C) $display("FAIL bpdu_word15: got %h required 3f3e3d3c", rd);
        else passed++;
        cfg_write(32'h8100_0040);
        wait_count(1, 1, 300, "bpdu_hdr_wait");
        total++;
        if (body_q.size() != 50) $display("FAIL bpdu_body_len: got %0d required 50", body_q.size());
        else passed++;
        errs = 0;
        for (int i = 0; i < body_q.size() && i < 50; i++) begin
            if (body_q[i] !== 8'(14 + i)) errs++;
            if (del_q[i] !== (i == 49)) errs++;
        end
        total++;
        if (errs != 0) $display("FAIL bpdu_body_data: got %0d wrong bytes/delimiters required 0", errs);
        else passed++;
        total++;
        if (hdr_q.size() < 1 || hdr_q[0] !== 128'h1004_0180C2000000_060708090A0B_0C0D)
            $display("FAIL bpdu_header: got %h required 10040180c2000000060708090a0b0c0d",
                     (hdr_q.size() > 0) ? hdr_q[0] : 128'hx);
        else passed++;
        cfg_read(rd);
        total++;
        if (rd !== 32'h8400_0000) $display("FAIL bpdu_cfg_after: got %h required 84000000", rd);
        else passed++;
    endtask

    task automatic test_min_len();
        clear_mon();
        write_frame(8'h55);
        cfg_write(32'h8200_000F);
        wait_count(1, 1, 100, "min_hdr_wait");
        total++;
        if (body_q.size() != 1 || body_q[0] !== 8'h5B || del_q[0] !== 1'b1)
            $display("FAIL min_len_body: got count=%0d byte=%h del=%b required 1/5b/1",
                     body_q.size(), (body_q.size() > 0) ? body_q[0] : 8'hx,
                     (del_q.size() > 0) ? del_q[0] : 1'bx);
        else passed++;
        total++;
        if (hdr_q.size() < 1 || hdr_q[0] !== 128'h2004_0180C2000000_53525D5C5F5E_5958)
            $display("FAIL min_len_header: got %h required 20040180c200000053525d5c5f5e5958",
                     (hdr_q.size() > 0) ? hdr_q[0] : 128'hx);
        else passed++;
    endtask

    task automatic test_backpressure();
        int errs;
        clear_mon();
        write_frame(8'hA0);
        @(posedge clk); #1; bus.h_fifo_full = 1'b1;
        cfg_write(32'h8400_0028);
        wait_count(0, 5, 100, "bp_body_start");
        @(posedge clk); #1; bus.b_fifo_full = 1'b1;
        repeat (5) @(posedge clk);
        #1; bus.b_fifo_full = 1'b0;
        wait_count(0, 26, 100, "bp_body_end");
        repeat (3) @(posedge clk);
        total++;
        if (hdr_q.size() != 0) $display("FAIL bp_hdr_early: got %0d headers required 0", hdr_q.size());
        else passed++;
        #1; bus.h_fifo_full = 1'b0;
        wait_count(1, 1, 50, "bp_hdr_wait");
        total++;
        if (b_viol != 0 || h_viol != 0)
            $display("FAIL bp_wren_while_full: got body=%0d hdr=%0d required 0/0", b_viol, h_viol);
        else passed++;
        errs = 0;
        for (int i = 0; i < body_q.size() && i < 26; i++) begin
            if (body_q[i] !== fbyte(14 + i, 8'hA0)) errs++;
            if (del_q[i] !== (i == 25)) errs++;
        end
        total++;
        if (body_q.size() != 26 || errs != 0)
            $display("FAIL bp_body: got count=%0d errors=%0d required 26/0", body_q.size(), errs);
        else passed++;
        total++;
        if (hdr_q.size() < 1 || hdr_q[0] !== exp_hdr(4'h4, 8'hA0))
            $display("FAIL bp_header: got %h required %h",
                     (hdr_q.size() > 0) ? hdr_q[0] : 128'hx, exp_hdr(4'h4, 8'hA0));
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int errs;
        clear_mon();
        @(posedge clk); #1; bus.b_fifo_full = 1'b1;
        write_frame(8'h40);
        cfg_write(32'h8100_0014);
        write_frame(8'h80);
        cfg_write(32'h8200_0014);
        cfg_read(rd);
        total++;
        if (rd !== 32'h5400_0000) $display("FAIL b2b_two_pending: got %h required 54000000", rd);
        else passed++;
        cfg_write(32'h8400_0014);
        cfg_read(rd);
        total++;
        if (rd !== 32'h7400_0000) $display("FAIL b2b_third_err: got %h required 74000000", rd);
        else passed++;
        cfg_write(32'h4000_0000);
        cfg_read(rd);
        total++;
        if (rd !== 32'h5400_0000) $display("FAIL b2b_clear_err: got %h required 54000000", rd);
        else passed++;
        total++;
        if (body_q.size() != 0 || hdr_q.size() != 0)
            $display("FAIL b2b_stalled: got body=%0d hdr=%0d required 0/0", body_q.size(), hdr_q.size());
        else passed++;
        @(posedge clk); #1; bus.b_fifo_full = 1'b0;
        wait_count(1, 2, 200, "b2b_hdr_wait");
        errs = 0;
        for (int i = 0; i < body_q.size() && i < 12; i++) begin
            if (body_q[i] !== fbyte(14 + (i % 6), (i < 6) ? 8'h40 : 8'h80)) errs++;
            if (del_q[i] !== (i == 5 || i == 11)) errs++;
        end
        total++;
        if (body_q.size() != 12 || errs != 0)
            $display("FAIL b2b_body: got count=%0d errors=%0d required 12/0", body_q.size(), errs);
        else passed++;
        total++;
        if (hdr_q.size() != 2 || hdr_q[0] !== exp_hdr(4'h1, 8'h40) || hdr_q[1] !== exp_hdr(4'h2, 8'h80))
            $display("FAIL b2b_headers: got count=%0d first=%h required 2 / %h", hdr_q.size(),
                     (hdr_q.size() > 0) ? hdr_q[0] : 128'hx, exp_hdr(4'h1, 8'h40));
        else passed++;
        cfg_read(rd);
        total++;
        if (rd !== 32'h8400_0000) $display("FAIL b2b_cfg_after: got %h required 84000000", rd);
        else passed++;
    endtask

    task automatic test_bad_len();
        logic [31:0] rd;
        logic [31:0] bad [3];
        bad[0] = 32'h8100_000E;
        bad[1] = 32'h8100_0041;
        bad[2] = 32'h8100_040F;
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            cfg_write(bad[i]);
            cfg_read(rd);
            total++;
            if (rd !== 32'hA400_0000) $display("FAIL bad_len_%0d: got %h required a4000000", i, rd);
            else passed++;
            if (i == 0) begin
                cfg_write(32'hC100_000E);
                cfg_read(rd);
                total++;
                if (rd !== 32'hA400_0000) $display("FAIL clear_with_fail: got %h required a4000000", rd);
                else passed++;
            end
            cfg_write(32'h4000_0000);
        end
        cfg_read(rd);
        total++;
        if (rd !== 32'h8400_0000) $display("FAIL bad_len_cleared: got %h required 84000000", rd);
        else passed++;
        repeat (10) @(posedge clk);
        total++;
        if (body_q.size() != 0 || hdr_q.size() != 0)
            $display("FAIL bad_len_fifo: got body=%0d hdr=%0d required 0/0", body_q.size(), hdr_q.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        clear_mon();
        write_frame(8'h33);
        cfg_write(32'h8100_0040);
        wait_count(0, 10, 100, "rst_body_wait");
        @(negedge clk); #2;
        arst_n = 1'b0;
        #1;
        total++;
        if ({bus.b_fifo_wren, bus.b_fifo_del_in, bus.h_fifo_wren, bus.iomem_ready} !== 4'b0)
            $display("FAIL reset_mid_strobes: got %b required 0000",
                     {bus.b_fifo_wren, bus.b_fifo_del_in, bus.h_fifo_wren, bus.iomem_ready});
        else passed++;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        cfg_read(rd);
        total++;
        if (rd !== 32'h8000_0000) $display("FAIL reset_mid_cfg: got %h required 80000000", rd);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_bpdu();
        test_min_len();
        test_backpressure();
        test_back_to_back();
        test_bad_len();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
